// File: rtl/dmem_mmio_pkg.sv
// Register map and TX_STATUS layout for the dmem_mmio data-side responder.
package dmem_mmio_pkg;

  localparam int REG_OFS_W = 5;

  localparam logic [REG_OFS_W-1:0] TX_DATA_OFS     = 5'h00;
  localparam logic [REG_OFS_W-1:0] TX_STATUS_OFS   = 5'h04;
  localparam logic [REG_OFS_W-1:0] CYC_SNAP_LO_OFS = 5'h08;
  localparam logic [REG_OFS_W-1:0] CYC_SNAP_HI_OFS = 5'h0C;
  localparam logic [REG_OFS_W-1:0] CYC_LIVE_LO_OFS = 5'h10;
  localparam logic [REG_OFS_W-1:0] DROP_CNT_OFS    = 5'h14;

  localparam int TX_STATUS_FULL_BIT  = 0;
  localparam int TX_STATUS_EMPTY_BIT = 1;
  localparam int TX_STATUS_COUNT_LSB = 8;
  localparam int TX_STATUS_COUNT_W   = 8;

  function automatic logic [31:0] pack_tx_status(input logic       full,
                                                 input logic       empty,
                                                 input logic [7:0] count);
    logic [31:0] word;
    word = '0;
    word[TX_STATUS_FULL_BIT]  = full;
    word[TX_STATUS_EMPTY_BIT] = empty;
    word[TX_STATUS_COUNT_LSB +: TX_STATUS_COUNT_W] = count;
    return word;
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// CPU data-memory port plus the TX byte stream toward the host.
interface dmem_mmio_if;

  logic        MemWrite;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;

  // TX stream: a byte transfers on every rising clk edge where tx_valid and
  // tx_ready are both 1; tx_valid/tx_data never depend on tx_ready.
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output MemWrite, Mem_WrAddr, Mem_WrData, tx_ready,
    input  ReadData, tx_data, tx_valid
  );

  modport slave (
    input  MemWrite, Mem_WrAddr, Mem_WrData, tx_ready,
    output ReadData, tx_data, tx_valid
  );

endinterface

// File: rtl/dmem_mmio_tx_fifo.sv
// First-word fall-through FIFO with an explicit occupancy count; a push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       push_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  always_comb begin
    full    = (count_q == DEPTH_C);
    empty   = (count_q == '0);
    do_pop  = pop && !empty;
    push_ok = push && (!full || do_pop);
    count   = count_q;
    // Empty head reads as zero so stale storage never leaks onto tx_data.
    head    = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(push_ok) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side responder for the single-cycle CPU: word RAM, 64-bit cycle counter
// with snapshot, and a byte TX FIFO, all readable combinationally.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h0000_4000,
  parameter int          TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  dmem_mmio_if.slave  bus
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
  localparam int          FIFO_CW   = $clog2(TX_DEPTH) + 1;

  logic [31:0] ram_q [RAM_WORDS];

  logic                  ram_hit;
  logic                  reg_hit;
  logic [REG_OFS_W-1:0]  reg_ofs;
  logic [RAM_AW-1:0]     ram_idx;

  logic                  tx_push;
  logic                  tx_pop;
  logic                  snap_we;
  logic                  drop_clr;

  logic [63:0]           cyc_q, cyc_d;
  logic [63:0]           snap_q, snap_d;
  logic [31:0]           drop_q, drop_d;

  logic [7:0]            fifo_head;
  logic [FIFO_CW-1:0]    fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push_ok;
  logic [7:0]            status_count;

  // Address decode; the low two address bits never take part in selection.
  always_comb begin
    ram_hit = (bus.Mem_WrAddr < RAM_BYTES);
    reg_hit = (bus.Mem_WrAddr[31:5] == MMIO_BASE[31:5]);
    reg_ofs = {bus.Mem_WrAddr[4:2], 2'b00};
    ram_idx = bus.Mem_WrAddr[RAM_AW+1:2];
  end

  always_comb begin
    tx_push  = bus.MemWrite && reg_hit && (reg_ofs == TX_DATA_OFS);
    snap_we  = bus.MemWrite && reg_hit && (reg_ofs == CYC_SNAP_LO_OFS);
    drop_clr = bus.MemWrite && reg_hit && (reg_ofs == DROP_CNT_OFS);
    tx_pop   = !fifo_empty && bus.tx_ready;
  end

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (bus.Mem_WrData[7:0]),
    .pop       (tx_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_ok   (fifo_push_ok)
  );

  always_comb begin
    bus.tx_data  = fifo_head;
    bus.tx_valid = !fifo_empty;
    status_count = 8'(fifo_count);
  end

  // Snapshot takes the counter value before this cycle's increment.
  always_comb begin
    cyc_d  = cyc_q + 64'd1;
    snap_d = snap_we ? cyc_q : snap_q;
    drop_d = drop_q;
    if (drop_clr) begin
      drop_d = '0;
    end else if (tx_push && !fifo_push_ok) begin
      drop_d = drop_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q  <= '0;
      snap_q <= '0;
      drop_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      snap_q <= snap_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.MemWrite && ram_hit) begin
      ram_q[ram_idx] <= bus.Mem_WrData;
    end
  end

  always_comb begin
    bus.ReadData = '0;
    if (ram_hit) begin
      bus.ReadData = ram_q[ram_idx];
    end else if (reg_hit) begin
      case (reg_ofs)
        TX_STATUS_OFS:   bus.ReadData = pack_tx_status(fifo_full, fifo_empty, status_count);
        CYC_SNAP_LO_OFS: bus.ReadData = snap_q[31:0];
        CYC_SNAP_HI_OFS: bus.ReadData = snap_q[63:32];
        CYC_LIVE_LO_OFS: bus.ReadData = cyc_q[31:0];
        DROP_CNT_OFS:    bus.ReadData = drop_q;
        default:         bus.ReadData = '0;
      endcase
    end
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side responder for the single-cycle `riscv_cpu`. It sits on the CPU's data-memory port (`MemWrite`, `Mem_WrAddr`, `Mem_WrData`, `ReadData`) and provides three things: a word RAM, a free-running 64-bit cycle counter with snapshot, and a byte TX FIFO. The FIFO drains to an off-chip host over a valid/ready handshake. Reads are combinational, so the single-cycle CPU completes loads in the same cycle.

## Interface
- `RAM_WORDS`, default 4096: RAM depth in 32-bit words, power of two; occupies byte addresses 0x0000_0000..4*RAM_WORDS-1.
- `MMIO_BASE`, default 32'h0000_4000: base of the register window; must be ≥ 4*RAM_WORDS.
- `TX_DEPTH`, default 8: TX FIFO depth in bytes, power of two, ≥ 2.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `MemWrite`  in  1  store strobe from CPU, full-word only.
- `Mem_WrAddr`  in  32  byte address for loads and stores.
- `Mem_WrData`  in  32  store data.
- `ReadData`  out  32  load data, combinational from `Mem_WrAddr`.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  host accepts `tx_data` this cycle.

## Operation
- **Addressing**
  - `Mem_WrAddr[1:0]` is ignored: word access only.
  - RAM hit: `Mem_WrAddr < 4*RAM_WORDS`.
  - Register hit: `Mem_WrAddr[31:5] == MMIO_BASE[31:5]`.
  - Anything else is unmapped: reads return 0, writes are ignored.
- **RAM**
  - Write `mem[addr[log2(RAM_WORDS)+1:2]] <= Mem_WrData` when `MemWrite` and RAM hit.
  - Contents are not reset.
- **Registers** (offsets from `MMIO_BASE`)
  - 0x00 TX_DATA (W)
    - Write pushes `Mem_WrData[7:0]`.
    - Read returns 0.
  - 0x04 TX_STATUS (R)
    - bit0 full, bit1 empty, bits[15:8] occupancy count.
    - All other bits 0.
  - 0x08 CYC_SNAP_LO (R/W)
    - Any write captures the full 64-bit counter into a snapshot register.
    - Read returns snapshot[31:0].
  - 0x0C CYC_SNAP_HI (R): snapshot[63:32].
  - 0x10 CYC_LIVE_LO (R): live counter[31:0].
  - 0x14 DROP_CNT (R/W)
    - Count of rejected pushes; wraps at 2^32.
    - Any write clears it.
  - 0x18, 0x1C: read 0, write ignored.
  - Writes to read-only registers are ignored.
- **Cycle counter**
  - 64-bit, +1 every cycle including the cycle a snapshot is taken.
  - Wraps 2^64-1 → 0.
  - Snapshot captures the pre-increment value in the write cycle.
- **TX FIFO** (first-word fall-through)
  - `tx_valid = (count != 0)`; `tx_data` = head byte.
  - Pop when `tx_valid && tx_ready`.
  - Push request = `MemWrite` to TX_DATA.
  - The push is accepted if `count < TX_DEPTH` or a pop occurs in the same cycle.
  - A rejected push increments DROP_CNT; FIFO contents are unchanged.
  - Simultaneous push and pop: count is unchanged, pointers both advance.
  - Pointers are log2(TX_DEPTH) bits and wrap naturally.
  - Full and empty are derived from an explicit count register (0..TX_DEPTH).
- **Reset** (synchronous)
  - FIFO pointers and count → 0.
  - Cycle counter, snapshot and DROP_CNT → 0.
  - Reset takes priority over a same-cycle push, pop or snapshot.
  - Bytes in flight are discarded.

## Timing
- Load latency 0: `ReadData` is a pure function of `Mem_WrAddr` and current state. After a write, the new value is visible the following cycle.
- Reset output values:
  - `tx_valid` = 0 and `tx_data` = 0 (head of empty FIFO is forced to 0).
  - `ReadData` = TX_STATUS 0x0000_0002 at 0x04, 0 at the other registers, RAM content at RAM addresses.
- Push-to-`tx_valid`: 1 cycle. `tx_valid` rises the cycle after the store.
- `tx_data` and `tx_valid` change only on `clk` edges; there is no combinational path from `tx_ready` to them.
- `tx_ready` with `tx_valid` = 0 has no effect.
- Full throughput: one push and one pop per cycle are sustained indefinitely.

## Structure
- Package `dmem_mmio_pkg`:
  - register offsets (`TX_DATA_OFS`, `TX_STATUS_OFS`, `CYC_SNAP_LO_OFS`, `CYC_SNAP_HI_OFS`, `CYC_LIVE_LO_OFS`, `DROP_CNT_OFS`);
  - TX_STATUS bit positions.
- Sub-module `tx_fifo`, parameterised by width (8) and depth.
  - Ports: `push`, `push_data`, `pop`, `head`, `count`, `full`, `empty`, `push_ok`.
- The top level holds the RAM array, counter, snapshot, DROP_CNT and the address-decode/read mux.

## Test plan
- Reset, then read 0x4004, 0x4008 and 0x4014 → 0x0000_0002, 0, 0; `tx_valid` = 0.
- RAM: store 0xDEAD_BEEF to 0x0000_0010, then load 0x0000_0013 → 0xDEAD_BEEF. Load 0x0001_0000 (unmapped) → 0.
- FIFO order: with `tx_ready` = 0, push 0x41, 0x42, 0x43; TX_STATUS → 0x0000_0300. Raise `tx_ready`: host sees 0x41, 0x42, 0x43 on three consecutive cycles, then `tx_valid` = 0.
- Overflow: `tx_ready` = 0, push 10 bytes with TX_DEPTH = 8 → TX_STATUS 0x0000_0801, DROP_CNT = 2, drained bytes are the first 8. Push to a full FIFO with `tx_ready` = 1 in the same cycle → accepted, DROP_CNT unchanged.
- Counter: write 0x4008 at cycle N after reset → snapshot LO = N, HI = 0; a later read of 0x4010 returns a value greater than N. Force the counter to 0xFFFF_FFFF_FFFF_FFFF in simulation → next cycle 0.
- Reset with 5 bytes queued and `tx_ready` = 1 → next cycle `tx_valid` = 0, count 0, DROP_CNT 0; a subsequent push of 0x55 appears as head.
